// File: rtl/spi_reg_host.sv
// SPI mode-0 host that issues single-register read/write frames: a REG_W-bit header then a REG_W-bit data phase.
// Optional macro SPI_REG_HOST_MISO_SYNC_EN adds a 2-flop synchroniser on spi_miso (requires CLK_DIV >= 6).
module spi_reg_host #(
  parameter int ADDR_W  = 3,
  parameter int REG_W   = 8,
  parameter int CLK_DIV = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rw,
  input  logic [1:0]        width,
  input  logic [ADDR_W-1:0] addr,
  input  logic [REG_W-1:0]  wdata,
  output logic              busy,
  output logic              done,
  output logic [REG_W-1:0]  rdata,
  output logic [REG_W-1:0]  status,
  output logic              spi_cs_n,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int FRAME_W = 2 * REG_W;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] HDR_LAST = BIT_W'(REG_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic               rd_q;
  logic [FRAME_W-1:0] tx_sr;
  logic [REG_W-1:0]   rx_sr;
  logic [REG_W-1:0]   stat_cap;
  logic [REG_W-1:0]   hdr;
  logic               miso_smp;
  logic               div_end;
  logic               rise_now;
  logic               fall_now;

`ifdef SPI_REG_HOST_MISO_SYNC_EN
  logic [1:0] miso_sync;
  always_ff @(posedge clk) begin
    miso_sync <= {miso_sync[0], spi_miso};
  end
  assign miso_smp = miso_sync[1];
`else
  assign miso_smp = spi_miso;
`endif

  always_comb begin
    hdr = '0;
    hdr[REG_W-1]      = rw;
    hdr[REG_W-2 -: 2] = width;
    hdr[ADDR_W-1:0]   = addr;
  end

  assign div_end  = (div_cnt == DIV_LAST);
  // SETUP expiry produces the first rising edge; later ones come from SHIFT with SCLK low
  assign rise_now = div_end && ((state == SETUP) || ((state == SHIFT) && !spi_clk));
  assign fall_now = div_end && (state == SHIFT) && spi_clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      rd_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
      rdata    <= '0;
      status   <= '0;
    end else begin
      done    <= 1'b0;
      div_cnt <= div_end ? '0 : div_cnt + 1'b1;
      case (state)
        IDLE: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          if (start) begin
            state    <= SETUP;
            rd_q     <= ~rw;
            busy     <= 1'b1;
            spi_cs_n <= 1'b0;
            spi_mosi <= rw;
          end
        end
        SETUP: begin
          if (div_end) begin
            state   <= SHIFT;
            spi_clk <= 1'b1;
          end
        end
        SHIFT: begin
          if (div_end) begin
            spi_clk <= ~spi_clk;
            if (spi_clk) begin
              if (bit_cnt == LAST_BIT) begin
                state    <= HOLD;
                spi_mosi <= 1'b0;
              end else begin
                bit_cnt  <= bit_cnt + 1'b1;
                spi_mosi <= tx_sr[FRAME_W-2];
              end
            end
          end
        end
        HOLD: begin
          if (div_end) begin
            state    <= GAP;
            spi_cs_n <= 1'b1;
          end
        end
        GAP: begin
          if (div_end) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            status <= stat_cap;
            if (rd_q) rdata <= rx_sr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // datapath shift registers carry no reset; their contents are only published via status/rdata
  always_ff @(posedge clk) begin
    if ((state == IDLE) && start) begin
      tx_sr <= {hdr, (rw ? wdata : {REG_W{1'b0}})};
    end else if (fall_now && (bit_cnt != LAST_BIT)) begin
      tx_sr <= tx_sr << 1;
    end
    if (rise_now) begin
      rx_sr <= {rx_sr[REG_W-2:0], miso_smp};
      if (bit_cnt == HDR_LAST) stat_cap <= {rx_sr[REG_W-2:0], miso_smp};
    end
  end

endmodule

// File: tb/tb_spi_reg_host.sv
// Directed bench for spi_reg_host with a behavioural SPI register target on the far side of the link.
`timescale 1ns/1ps
module tb_spi_reg_host;
`ifdef SPI_REG_HOST_MISO_SYNC_EN
  localparam int D = 6;
`else
  localparam int D = 8;
`endif
  localparam int DONE_CYC = 1 + D * (4 * 8 + 2);
  localparam int CSHI_CYC = 1 + D * (4 * 8 + 1);

  logic       clk = 1'b0;
  logic       rst, start, rw;
  logic [1:0] width;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic       busy, done;
  logic [7:0] rdata, status;
  logic       spi_cs_n, spi_clk, spi_mosi;
  logic       spi_miso = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_reg_host #(.ADDR_W(3), .REG_W(8), .CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .width(width), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .status(status),
    .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  // Target model: status byte during header, register data during a read's data phase.
  logic [7:0]  tgt_status = 8'h00;
  logic [7:0]  tgt_rdata  = 8'h00;
  logic [7:0]  s_tx = 8'h00;
  logic [15:0] s_rx = 16'h0000;
  int          s_cnt = 0;
  logic        p_cs = 1'b1, p_sck = 1'b0;

  always @(spi_cs_n or spi_clk) begin
    if (p_cs && !spi_cs_n) begin
      s_tx = tgt_status; s_cnt = 0; s_rx = 16'h0000; spi_miso = s_tx[7];
    end else if (!spi_cs_n && !p_sck && spi_clk) begin
      s_rx = {s_rx[14:0], spi_mosi}; s_cnt++;
    end else if (!spi_cs_n && p_sck && !spi_clk) begin
      if (s_cnt == 8) s_tx = s_rx[7] ? 8'h00 : tgt_rdata;
      else s_tx = {s_tx[6:0], 1'b0};
      spi_miso = s_tx[7];
    end
    p_cs = spi_cs_n; p_sck = spi_clk;
  end

  // Frame observations
  int   done_t, cshi_t, nrise, nfall, edge_err, bad_mosi, bad_sclk;
  logic c1_csn, c1_busy;

  task automatic run_frame(input bit pre, input logic rw_i, input logic [1:0] w_i,
                           input logic [2:0] a_i, input logic [7:0] d_i,
                           input int s1, input int s2, input bit chain,
                           input logic c_rw, input logic [1:0] c_w,
                           input logic [2:0] c_a, input logic [7:0] c_d);
    int n;
    logic ps, pc, pm;
    if (!pre) begin
      @(negedge clk);
      rw = rw_i; width = w_i; addr = a_i; wdata = d_i; start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0; rw = ~rw_i; width = ~w_i; addr = ~a_i; wdata = ~d_i;
    n = 1; done_t = -1; cshi_t = -1; nrise = 0; nfall = 0;
    edge_err = 0; bad_mosi = 0; bad_sclk = 0;
    c1_csn = spi_cs_n; c1_busy = busy;
    ps = spi_clk; pc = spi_cs_n; pm = spi_mosi;
    while (n < 4000) begin
      if (spi_clk && !ps) begin
        if (n != 1 + D * (2 * nrise + 1)) edge_err++;
        if (spi_mosi !== pm) bad_mosi++;
        nrise++;
      end
      if (!spi_clk && ps) begin
        if (n != 1 + D * (2 * nfall + 2)) edge_err++;
        nfall++;
      end
      if (spi_cs_n && !pc && cshi_t < 0) cshi_t = n;
      if (spi_cs_n && spi_clk) bad_sclk++;
      if (done === 1'b1) begin done_t = n; break; end
      ps = spi_clk; pc = spi_cs_n; pm = spi_mosi;
      start = (n == s1) || (n == s2);
      @(posedge clk); #1; n++;
    end
    start = 1'b0;
    if (chain && done_t > 0) begin
      rw = c_rw; width = c_w; addr = c_a; wdata = c_d; start = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rw = 1'b0; width = 2'b00; addr = 3'd0; wdata = 8'h00;
    repeat (3) @(posedge clk); #1;
    checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", spi_cs_n); end
    checks++; if (spi_clk !== 1'b0) begin errors++; $display("FAIL reset_spi_clk: got %b expected 0", spi_clk); end
    checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", spi_mosi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
    checks++; if (status !== 8'h00) begin errors++; $display("FAIL reset_status: got %h expected 00", status); end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_write();
    tgt_status = 8'h5A;
    run_frame(1'b0, 1'b1, 2'b11, 3'd5, 8'hA5, 0, 0, 1'b0, 1'b0, 2'b00, 3'd0, 8'h00);
    checks++; if (c1_csn !== 1'b0 || c1_busy !== 1'b1) begin errors++; $display("FAIL write_cycle1: got cs_n=%b busy=%b expected cs_n=0 busy=1", c1_csn, c1_busy); end
    checks++; if (s_rx !== 16'hE5A5) begin errors++; $display("FAIL write_mosi: got %h expected E5A5", s_rx); end
    checks++; if (done_t != DONE_CYC) begin errors++; $display("FAIL write_done_cycle: got %0d expected %0d", done_t, DONE_CYC); end
    checks++; if (cshi_t != CSHI_CYC) begin errors++; $display("FAIL write_cs_high_cycle: got %0d expected %0d", cshi_t, CSHI_CYC); end
    checks++; if (nrise != 16 || nfall != 16 || edge_err != 0) begin errors++; $display("FAIL write_sclk_edges: got rises=%0d falls=%0d misplaced=%0d expected 16 16 0", nrise, nfall, edge_err); end
    checks++; if (bad_mosi != 0 || bad_sclk != 0) begin errors++; $display("FAIL write_mosi_sclk_rules: got mosi_on_rise=%0d sclk_with_cs_high=%0d expected 0 0", bad_mosi, bad_sclk); end
    checks++; if (status !== 8'h5A) begin errors++; $display("FAIL write_status: got %h expected 5A", status); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL write_rdata_kept: got %h expected 00", rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_at_done: got %b expected 0", busy); end
  endtask

  task automatic test_read();
    tgt_status = 8'h81; tgt_rdata = 8'h3C;
    run_frame(1'b0, 1'b0, 2'b11, 3'd3, 8'hFF, 0, 0, 1'b0, 1'b0, 2'b00, 3'd0, 8'h00);
    checks++; if (status !== 8'h81) begin errors++; $display("FAIL read_status: got %h expected 81", status); end
    checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL read_rdata: got %h expected 3C", rdata); end
    checks++; if (s_rx !== 16'h6300) begin errors++; $display("FAIL read_mosi: got %h expected 6300", s_rx); end
    checks++; if (done_t != DONE_CYC) begin errors++; $display("FAIL read_done_cycle: got %0d expected %0d", done_t, DONE_CYC); end
  endtask

  task automatic test_write_after_read();
    tgt_status = 8'h42; tgt_rdata = 8'h99;
    run_frame(1'b0, 1'b1, 2'b01, 3'd6, 8'h17, 0, 0, 1'b0, 1'b0, 2'b00, 3'd0, 8'h00);
    checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL war_rdata_kept: got %h expected 3C", rdata); end
    checks++; if (status !== 8'h42) begin errors++; $display("FAIL war_status: got %h expected 42", status); end
    checks++; if (s_rx !== 16'hA617) begin errors++; $display("FAIL war_mosi: got %h expected A617", s_rx); end
  endtask

  task automatic test_busy_ignore();
    int bad;
    tgt_status = 8'h11;
    run_frame(1'b0, 1'b1, 2'b01, 3'd2, 8'h3C, 50, 150, 1'b0, 1'b0, 2'b00, 3'd0, 8'h00);
    checks++; if (done_t != DONE_CYC || nrise != 16) begin errors++; $display("FAIL ignore_frame: got done=%0d rises=%0d expected %0d 16", done_t, nrise, DONE_CYC); end
    checks++; if (s_rx !== 16'hA23C) begin errors++; $display("FAIL ignore_mosi: got %h expected A23C", s_rx); end
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || done !== 1'b0 || spi_cs_n !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ignore_no_second_frame: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_back_to_back();
    tgt_status = 8'h24; tgt_rdata = 8'h96;
    run_frame(1'b0, 1'b1, 2'b00, 3'd7, 8'hFF, 0, 0, 1'b1, 1'b0, 2'b10, 3'd1, 8'h00);
    checks++; if (s_rx !== 16'h87FF || done_t != DONE_CYC) begin errors++; $display("FAIL b2b_first: got mosi=%h done=%0d expected 87FF %0d", s_rx, done_t, DONE_CYC); end
    run_frame(1'b1, 1'b0, 2'b10, 3'd1, 8'h00, 0, 0, 1'b0, 1'b0, 2'b00, 3'd0, 8'h00);
    checks++; if (c1_csn !== 1'b0 || c1_busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got cs_n=%b busy=%b expected 0 1", c1_csn, c1_busy); end
    checks++; if (s_rx !== 16'h4100 || rdata !== 8'h96 || done_t != DONE_CYC) begin errors++; $display("FAIL b2b_second: got mosi=%h rdata=%h done=%0d expected 4100 96 %0d", s_rx, rdata, done_t, DONE_CYC); end
  endtask

  task automatic test_reset_mid_frame();
    int dones, cs_low;
    tgt_status = 8'h77; tgt_rdata = 8'hEE;
    @(negedge clk); rw = 1'b0; width = 2'b11; addr = 3'd4; wdata = 8'h00; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (99) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if (spi_cs_n !== 1'b1 || spi_clk !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_async: got cs_n=%b sclk=%b busy=%b expected 1 0 0", spi_cs_n, spi_clk, busy); end
    checks++; if (rdata !== 8'h00 || status !== 8'h00) begin errors++; $display("FAIL midrst_latches: got rdata=%h status=%h expected 00 00", rdata, status); end
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    dones = 0; cs_low = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (done !== 1'b0) dones++;
      if (spi_cs_n !== 1'b1) cs_low++;
    end
    checks++; if (dones != 0 || cs_low != 0) begin errors++; $display("FAIL midrst_abandoned: got done_cycles=%0d cs_low_cycles=%0d expected 0 0", dones, cs_low); end
    tgt_status = 8'h18; tgt_rdata = 8'h5E;
    run_frame(1'b0, 1'b0, 2'b01, 3'd4, 8'h00, 0, 0, 1'b0, 1'b0, 2'b00, 3'd0, 8'h00);
    checks++; if (rdata !== 8'h5E || status !== 8'h18 || s_rx !== 16'h2400 || done_t != DONE_CYC) begin errors++; $display("FAIL midrst_recover: got rdata=%h status=%h mosi=%h done=%0d expected 5E 18 2400 %0d", rdata, status, s_rx, done_t, DONE_CYC); end
  endtask

  task automatic test_read_c3();
    tgt_status = 8'hFF; tgt_rdata = 8'hC3;
    run_frame(1'b0, 1'b0, 2'b00, 3'd0, 8'h00, 0, 0, 1'b0, 1'b0, 2'b00, 3'd0, 8'h00);
    checks++; if (rdata !== 8'hC3) begin errors++; $display("FAIL c3_rdata: got %h expected C3", rdata); end
    checks++; if (status !== 8'hFF) begin errors++; $display("FAIL c3_status: got %h expected FF", status); end
    checks++; if (nrise != 16 || nfall != 16 || edge_err != 0 || cshi_t != CSHI_CYC) begin errors++; $display("FAIL c3_timing: got rises=%0d falls=%0d misplaced=%0d cs_high=%0d expected 16 16 0 %0d", nrise, nfall, edge_err, cshi_t, CSHI_CYC); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_write_after_read();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_frame();
    test_read_c3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
